pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the 16-bit CPU.
- Holds the PC and runs a fetch/execute handshake with instruction memory.
- Latches the fetched instruction for the decoder and computes the next PC on the control unit's update strobe.
- Provides the PC+1 link value that feeds the write-back select mux as one of its four 16-bit data inputs for jump-and-link.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- DISP_W, 8, width of the signed branch displacement taken from instruction bits [DISP_W-1:0].

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- mem_req  output  1  fetch request, high while in FETCH
- mem_addr  output  16  fetch address, equals pc
- mem_ready  input  1  memory has valid mem_rdata this cycle
- mem_rdata  input  16  instruction word from memory
- instr  output  16  latched instruction
- instr_valid  output  1  high while in EXEC (instr stable)
- pc_update  input  1  one-cycle strobe from control: instruction complete, advance PC
- pc_sel  input  2  next-PC source: 00 sequential, 01 branch, 10 jump to register, 11 hold
- branch_taken  input  1  branch condition result, used only when pc_sel=01
- jump_target  input  16  register-sourced jump address
- pc  output  16  current PC
- pc_link  output  16  pc+1, combinational, to write-back mux
- retired_count  output  16  count of completed instructions

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-low: sampled only on the rising edge of `clk`; reset is applied while reset==0.
- Reset values: pc=RESET_VECTOR, instr=16'h0000, retired_count=0, state=IDLE, so mem_req=0 and instr_valid=0.
- State machine:
  - IDLE: go to FETCH on the next clock.
  - The first mem_req therefore rises one cycle after reset releases.
- FETCH:
  - mem_req=1, mem_addr=pc.
  - On mem_ready=1: instr<=mem_rdata, go to EXEC.
  - mem_req is low in the following cycle.
  - Waits indefinitely for mem_ready.
  - pc_update is ignored in FETCH.
- EXEC:
  - instr_valid=1; instr and pc are held stable.
  - mem_ready is ignored.
  - On pc_update=1: load the next PC, retired_count<=retired_count+1, go to FETCH.
  - Without pc_update, stays in EXEC.
- Next-PC rules (all 16-bit, modulo 2^16, wrap silently):
  - 00: pc+1.
  - 01: if branch_taken, pc+1+sign_extend(instr[DISP_W-1:0]); else pc+1.
  - 10: jump_target.
  - 11: pc unchanged. The same address is refetched and the instruction still counts as retired.
- Latency:
  - Minimum two cycles per instruction: FETCH with mem_ready high, then EXEC with pc_update high.
  - The next fetch is issued in the cycle after pc_update.
- pc_link: always pc+1 (combinational); 16'hFFFF wraps to 16'h0000.
- retired_count: wraps from 16'hFFFF to 16'h0000.
- Simultaneous events: reset==0 overrides everything, including a coincident mem_ready or pc_update.
- Reset mid-operation: an outstanding fetch is abandoned, mem_req drops in the next cycle, and the machine returns to IDLE. Memory must tolerate request withdrawal.
- No X propagation: all registers are assigned in reset.

Test Plan:
- Reset/boot: hold reset=0 3 cycles, release -> mem_req=0 first cycle, =1 second, mem_addr=16'h0000, instr_valid=0, retired_count=0.
- Sequential: mem_ready with rdata 16'h1234, then pc_update, pc_sel=00 -> instr=16'h1234 during EXEC, pc=0001, retired_count=1, mem_req=1 next cycle.
- Branch: pc=16'h0010, instr[7:0]=8'hFC, pc_sel=01:
  - branch_taken=1 -> pc=16'h000D.
  - Repeat with branch_taken=0 -> pc=16'h0011.
- Jump/wrap: pc_sel=10, jump_target=16'hFFFF -> pc=FFFF, pc_link=0000; next sequential update -> pc=16'h0000.
- Handshake stalls:
  - mem_ready low 5 cycles in FETCH -> mem_req stays 1, instr unchanged.
  - pc_update pulses during FETCH are ignored.
  - mem_ready pulses during EXEC do not alter instr.
- Reset mid-fetch: assert reset while mem_req=1 at pc=16'h0042 -> next cycle pc=RESET_VECTOR, mem_req=0, retired_count=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage of the 16-bit CPU.
// Runs the fetch/execute handshake with instruction memory and computes the next PC.
module pc_fetch_unit #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int          DISP_W       = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        pc_update,
   input  logic [1:0]  pc_sel,
   input  logic        branch_taken,
   input  logic [15:0] jump_target,
   output logic [15:0] pc,
   output logic [15:0] pc_link,
   output logic [15:0] retired_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] pc_q;
   logic [15:0] instr_q;
   logic [15:0] retired_q;
   logic [15:0] pc_plus1;
   logic [15:0] disp_ext;
   logic [15:0] next_pc;

   assign pc_plus1 = pc_q + 16'd1;
   assign disp_ext = 16'($signed(instr_q[DISP_W-1:0]));

   // Branch displacement is relative to the sequential successor, not the branch itself
   always_comb begin
      next_pc = pc_plus1;
      case (pc_sel)
         2'b00:   next_pc = pc_plus1;
         2'b01:   next_pc = branch_taken ? (pc_plus1 + disp_ext) : pc_plus1;
         2'b10:   next_pc = jump_target;
         default: next_pc = pc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         pc_q      <= RESET_VECTOR;
         instr_q   <= 16'h0000;
         retired_q <= 16'h0000;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (mem_ready) begin
                  instr_q <= mem_rdata;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               if (pc_update) begin
                  pc_q      <= next_pc;
                  retired_q <= retired_q + 16'd1;
                  state     <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs decode straight from the state register, so they never glitch
   assign mem_req       = (state == FETCH);
   assign instr_valid   = (state == EXEC);
   assign mem_addr      = pc_q;
   assign pc            = pc_q;
   assign instr         = instr_q;
   assign pc_link       = pc_plus1;
   assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected fetch/exec views,
// a negedge monitor pops and compares them whenever mem_req or instr_valid rises.
module tb_pc_fetch_unit;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        pc_update;
   logic [1:0]  pc_sel;
   logic        branch_taken;
   logic [15:0] jump_target;
   logic [15:0] pc;
   logic [15:0] pc_link;
   logic [15:0] retired_count;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] retired;
   } fetch_exp_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
   } exec_exp_t;

   fetch_exp_t fetchQ[$];
   exec_exp_t  execQ[$];

   int checks   = 0;
   int failures = 0;

   pc_fetch_unit #(.RESET_VECTOR(16'h0000), .DISP_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .pc_update    (pc_update),
      .pc_sel       (pc_sel),
      .branch_taken (branch_taken),
      .jump_target  (jump_target),
      .pc           (pc),
      .pc_link      (pc_link),
      .retired_count(retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic [15:0] rdata, input logic upd,
                                input logic [1:0] sel, input logic taken, input logic [15:0] target);
      mem_ready    = ready;
      mem_rdata    = rdata;
      pc_update    = upd;
      pc_sel       = sel;
      branch_taken = taken;
      jump_target  = target;
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      mem_ready    = 1'b0;
      pc_update    = 1'b0;
      pc_sel       = 2'b00;
      branch_taken = 1'b0;
   endtask

   task automatic waitFetch();
      int n = 0;
      while (mem_req !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (mem_req !== 1'b1) checkOutput("wait_fetch_timeout", {15'd0, mem_req}, 16'd1);
   endtask

   task automatic waitExec();
      int n = 0;
      while (instr_valid !== 1'b1 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (instr_valid !== 1'b1) checkOutput("wait_exec_timeout", {15'd0, instr_valid}, 16'd1);
   endtask

   task automatic doFetch(input logic [15:0] rdata, input logic [15:0] expPc);
      exec_exp_t e;
      waitFetch();
      e.instr = rdata;
      e.pc    = expPc;
      execQ.push_back(e);
      applyStimulus(1'b1, rdata, 1'b0, 2'b00, 1'b0, 16'h0000);
      clearInputs();
   endtask

   task automatic doRetire(input logic [1:0] sel, input logic taken, input logic [15:0] target,
                           input logic [15:0] expPc, input logic [15:0] expRetired);
      fetch_exp_t f;
      waitExec();
      f.addr    = expPc;
      f.retired = expRetired;
      fetchQ.push_back(f);
      applyStimulus(1'b0, 16'h0000, 1'b1, sel, taken, target);
      clearInputs();
   endtask

   // Monitor: compares the DUT's view at each new fetch request and each new EXEC entry
   logic prevReq   = 1'b0;
   logic prevValid = 1'b0;
   always @(negedge clk) begin
      if (mem_req === 1'b1 && !prevReq) begin
         if (fetchQ.size() == 0) begin
            checkOutput("unexpected_fetch", mem_addr, 16'hxxxx);
         end else begin
            fetch_exp_t f;
            f = fetchQ.pop_front();
            checkOutput("fetch_addr", mem_addr, f.addr);
            checkOutput("fetch_pc_link", pc_link, f.addr + 16'd1);
            checkOutput("fetch_retired", retired_count, f.retired);
         end
      end
      if (instr_valid === 1'b1 && !prevValid) begin
         if (execQ.size() == 0) begin
            checkOutput("unexpected_exec", instr, 16'hxxxx);
         end else begin
            exec_exp_t e;
            e = execQ.pop_front();
            checkOutput("exec_instr", instr, e.instr);
            checkOutput("exec_pc", pc, e.pc);
            checkOutput("exec_no_req", {15'd0, mem_req}, 16'd0);
         end
      end
      prevReq   = (mem_req === 1'b1);
      prevValid = (instr_valid === 1'b1);
   end

   initial begin
      fetch_exp_t f;
      mem_rdata   = 16'h0000;
      jump_target = 16'h0000;
      clearInputs();
      reset = 1'b0;

      // Boot
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_mem_req", {15'd0, mem_req}, 16'd0);
      checkOutput("rst_instr_valid", {15'd0, instr_valid}, 16'd0);
      checkOutput("rst_pc", pc, 16'h0000);
      checkOutput("rst_retired", retired_count, 16'h0000);
      checkOutput("rst_instr", instr, 16'h0000);
      f.addr = 16'h0000;
      f.retired = 16'h0000;
      fetchQ.push_back(f);
      reset = 1'b1;
      #1;
      checkOutput("boot_first_cycle_req", {15'd0, mem_req}, 16'd0);
      @(posedge clk);
      #1;
      checkOutput("boot_second_cycle_req", {15'd0, mem_req}, 16'd1);
      checkOutput("boot_mem_addr", mem_addr, 16'h0000);

      // FETCH stall with pc_update pulses that must be ignored
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 16'hBEEF, i[0], 2'b10, 1'b0, 16'h5555);
         checkOutput("stall_mem_req", {15'd0, mem_req}, 16'd1);
         checkOutput("stall_instr", instr, 16'h0000);
         checkOutput("stall_pc", pc, 16'h0000);
      end
      clearInputs();

      doFetch(16'h1234, 16'h0000);
      // mem_ready pulses during EXEC must not disturb instr
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 16'hDEAD, 1'b0, 2'b00, 1'b0, 16'h0000);
         checkOutput("exec_hold_instr", instr, 16'h1234);
         checkOutput("exec_hold_valid", {15'd0, instr_valid}, 16'd1);
      end
      clearInputs();
      doRetire(2'b00, 1'b0, 16'h0000, 16'h0001, 16'd1);
      checkOutput("seq_pc", pc, 16'h0001);
      checkOutput("seq_req_next", {15'd0, mem_req}, 16'd1);

      doFetch(16'h0000, 16'h0001);
      doRetire(2'b10, 1'b0, 16'h0010, 16'h0010, 16'd2);

      // Branch back by 4 from 0x0010 -> 0x0011 - 4
      doFetch(16'h12FC, 16'h0010);
      doRetire(2'b01, 1'b1, 16'hAAAA, 16'h000D, 16'd3);
      doFetch(16'h0000, 16'h000D);
      doRetire(2'b10, 1'b0, 16'h0010, 16'h0010, 16'd4);
      doFetch(16'h00FC, 16'h0010);
      doRetire(2'b01, 1'b0, 16'hAAAA, 16'h0011, 16'd5);

      doFetch(16'h0005, 16'h0011);
      doRetire(2'b01, 1'b1, 16'h0000, 16'h0017, 16'd6);

      // Hold: same address refetched, still retired
      doFetch(16'h0000, 16'h0017);
      doRetire(2'b11, 1'b0, 16'h0000, 16'h0017, 16'd7);

      doFetch(16'h7777, 16'h0017);
      doRetire(2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 16'd8);
      checkOutput("jump_pc", pc, 16'hFFFF);
      checkOutput("wrap_pc_link", pc_link, 16'h0000);
      doFetch(16'h0001, 16'hFFFF);
      doRetire(2'b00, 1'b0, 16'h0000, 16'h0000, 16'd9);

      // Reset mid-fetch with a coincident mem_ready
      doFetch(16'h0000, 16'h0000);
      doRetire(2'b10, 1'b0, 16'h0042, 16'h0042, 16'd10);
      checkOutput("pre_rst_addr", mem_addr, 16'h0042);
      f.addr = 16'h0000;
      f.retired = 16'h0000;
      fetchQ.push_back(f);
      reset = 1'b0;
      applyStimulus(1'b1, 16'h9999, 1'b0, 2'b00, 1'b0, 16'h0000);
      clearInputs();
      checkOutput("midrst_pc", pc, 16'h0000);
      checkOutput("midrst_mem_req", {15'd0, mem_req}, 16'd0);
      checkOutput("midrst_retired", retired_count, 16'h0000);
      checkOutput("midrst_instr", instr, 16'h0000);
      reset = 1'b1;
      waitFetch();
      repeat (2) @(posedge clk);
      #1;

      checkOutput("fetchQ_drained", 16'(fetchQ.size()), 16'd0);
      checkOutput("execQ_drained", 16'(execQ.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
